// File: rtl/spi_dac_multi.sv
// spi_dac_multi: multi-channel SPI driver for AD5541A-class DACs (write-only, MSB first, SCLK idles high).
// Samples arrive per channel over a valid/ready stream into shadow registers. Every sample tick
// snapshots all shadows and shifts one frame per channel, each under its own chip select.
// Optional feature macro: SPI_DAC_LDAC_EN -- when defined, a shared LDAC pulse follows the last
// channel so all DACs update together; when undefined, ldac_n is tied low and each DAC updates on
// its own cs_n rise.
//
// Stream handshake: a sample is taken in every cycle where s_axis_valid && s_axis_ready.
// s_axis_ready is high whenever the block is out of reset. Channel numbers >= NUM_CH are
// accepted and discarded.
module spi_dac_multi #(
    parameter int DATA_W          = 16,
    parameter int NUM_CH          = 1,
    parameter int MCLK_PER_SAMPLE = 200,
    parameter int SCLK_DIV        = 8,
    parameter int LDAC_CYCLES     = 2
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                s_axis_valid,
    output logic                s_axis_ready,
    input  logic [DATA_W-1:0]   s_axis_data,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] s_axis_chan,
    output logic [NUM_CH-1:0]   cs_n,
    output logic                sclk,
    output logic                mosi,
    output logic                ldac_n,
    output logic                busy,
    output logic                underrun,
    output logic                overrun,
    output logic [2:0]          dbg_state
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (MCLK_PER_SAMPLE > 1) ? $clog2(MCLK_PER_SAMPLE) : 1;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5,
        S_LDAC  = 3'd6
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [NUM_CH*DATA_W-1:0]   r_shadow;
    logic [NUM_CH-1:0]          r_fresh;
    logic [NUM_CH*DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]          r_sh;
    logic [CH_W-1:0]            r_ch;
    logic [DIV_W-1:0]           r_div;
    logic [BIT_W-1:0]           r_bit;
    logic [NUM_CH-1:0]          r_cs_n;
    logic                       r_sclk;
    logic                       r_mosi;
    logic                       r_busy;
    logic                       r_underrun;
    logic                       r_overrun;

    logic                       w_tick;
    logic [NUM_CH-1:0]          w_wr;
    logic [CH_W-1:0]            w_ch_nxt;
    logic [NUM_CH-1:0]          w_cs_sel;
    logic [DATA_W-1:0]          w_word;

    assign w_tick   = en && (r_cnt == CNT_W'(MCLK_PER_SAMPLE - 1));
    assign w_ch_nxt = (r_state == S_LOAD) ? '0 : r_ch + 1'b1;
    assign w_word   = r_tx[int'(r_ch)*DATA_W +: DATA_W];

    // Decode the write-enable per channel and the chip select of the next frame.
    always_comb begin
        w_wr     = '0;
        w_cs_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i]     = s_axis_valid && (s_axis_chan == CH_W'(i));
            w_cs_sel[i] = (w_ch_nxt == CH_W'(i));
        end
    end

    // Sample tick counter; held at zero while disabled.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)       r_cnt <= '0;
        else if (!en)     r_cnt <= '0;
        else if (w_tick)  r_cnt <= '0;
        else              r_cnt <= r_cnt + 1'b1;
    end

    // Shadow registers and fresh flags; LOAD clears the flags but a same-cycle write still lands.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_fresh  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr[i]) r_shadow[i*DATA_W +: DATA_W] <= s_axis_data;
            end
            if (r_state == S_LOAD) r_fresh <= w_wr;
            else                   r_fresh <= r_fresh | w_wr;
        end
    end

`ifdef SPI_DAC_LDAC_EN
    localparam int LD_W = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;
    logic [LD_W-1:0] r_ld_cnt;
    logic            r_ldac_n;
`endif

    // Frame sequencer: snapshot, then per channel CS setup, DATA_W SCLK periods, CS hold, CS gap.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx       <= '0;
            r_sh       <= '0;
            r_ch       <= '0;
            r_div      <= '0;
            r_bit      <= '0;
            r_cs_n     <= '1;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
            r_ld_cnt   <= '0;
            r_ldac_n   <= 1'b1;
`endif
        end else begin
            r_underrun <= 1'b0;
            r_overrun  <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state    <= S_LOAD;
                        r_busy     <= 1'b1;
                        r_underrun <= ~&(r_fresh | w_wr);
                    end
                end
                S_LOAD: begin
                    r_tx    <= r_shadow;
                    r_ch    <= w_ch_nxt;
                    r_cs_n  <= ~w_cs_sel;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_state <= S_SHIFT;
                    r_sclk  <= 1'b0;
                    r_mosi  <= w_word[DATA_W-1];
                    r_sh    <= w_word << 1;
                    r_div   <= '0;
                    r_bit   <= '0;
                end
                S_SHIFT: begin
                    r_div <= r_div + 1'b1;
                    if (r_div == DIV_W'(SCLK_DIV/2 - 1)) r_sclk <= 1'b1;
                    if (r_div == DIV_W'(SCLK_DIV - 1)) begin
                        r_div <= '0;
                        if (r_bit == BIT_W'(DATA_W - 1)) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_sclk <= 1'b0;
                            r_mosi <= r_sh[DATA_W-1];
                            r_sh   <= r_sh << 1;
                        end
                    end
                end
                S_HOLD: begin
                    r_state <= S_GAP;
                    r_cs_n  <= '1;
                    r_mosi  <= 1'b0;
                end
                S_GAP: begin
                    if (r_ch != CH_W'(NUM_CH - 1)) begin
                        r_ch    <= w_ch_nxt;
                        r_cs_n  <= ~w_cs_sel;
                        r_state <= S_SETUP;
                    end else begin
`ifdef SPI_DAC_LDAC_EN
                        r_state  <= S_LDAC;
                        r_ldac_n <= 1'b0;
                        r_ld_cnt <= '0;
`else
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
`endif
                    end
                end
`ifdef SPI_DAC_LDAC_EN
                S_LDAC: begin
                    if (r_ld_cnt == LD_W'(LDAC_CYCLES - 1)) begin
                        r_ldac_n <= 1'b1;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_DAC_LDAC_EN
    assign ldac_n = r_ldac_n;
`else
    assign ldac_n = 1'b0;
`endif

    assign s_axis_ready = rst_n;
    assign cs_n         = r_cs_n;
    assign sclk         = r_sclk;
    assign mosi         = r_mosi;
    assign busy         = r_busy;
    assign underrun     = r_underrun;
    assign overrun      = r_overrun;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_spi_dac_multi.sv
// tb_spi_dac_multi: randomized bench for spi_dac_multi with a frame-level reference model.
// Frame length here exceeds the sample period, so back-to-back ticks overrun by design;
// single-frame scenarios pulse en for exactly one tick.
module tb_spi_dac_multi;
  localparam int DW  = 16;
  localparam int NCH = 3;
  localparam int MPS = 150;
  localparam int DIV = 4;
  localparam int LDC = 2;
  localparam int CHW = 2;
  localparam int P   = DW*DIV + 3;
`ifdef SPI_DAC_LDAC_EN
  localparam int F   = 1 + NCH*P + LDC;
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam int F   = 1 + NCH*P;
  localparam logic LDAC_IDLE = 1'b0;
`endif

  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic s_axis_valid = 1'b0;
  logic s_axis_ready;
  logic [DW-1:0] s_axis_data = '0;
  logic [CHW-1:0] s_axis_chan = '0;
  logic [NCH-1:0] cs_n;
  logic sclk, mosi, ldac_n, busy, underrun, overrun;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  spi_dac_multi #(.DATA_W(DW), .NUM_CH(NCH), .MCLK_PER_SAMPLE(MPS), .SCLK_DIV(DIV), .LDAC_CYCLES(LDC)) dut (
    .mclk(mclk), .rst_n(rst_n), .en(en), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_chan(s_axis_chan), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .ldac_n(ldac_n), .busy(busy), .underrun(underrun), .overrun(overrun), .dbg_state(dbg_state)
  );

  typedef struct {
    int ch;
    logic [DW-1:0] word;
    int start;
    int len;
    int nbits;
  } frame_t;

  frame_t exp_q[$], obs_q[$];
  int exp_under_q[$], obs_under_q[$];
  int exp_over_q[$], obs_over_q[$];
  int exp_load_q[$], obs_load_q[$];
  int exp_ldac_q[$], obs_ldac_q[$];
  int cyc = 0;

  // reference model: shadows, fresh flags, tick period, frame timing by arithmetic
  logic [DW-1:0] m_shadow [NCH];
  logic [NCH-1:0] m_fresh;
  int m_cnt = 0;
  bit m_load_pend = 0;
  int m_busy_end = 0;
  frame_t m_f;

  always @(posedge mclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
      m_fresh = '0;
      m_cnt = 0;
      m_load_pend = 0;
      m_busy_end = 0;
    end else begin
      if (m_load_pend) begin
        for (int c = 0; c < NCH; c++) begin
          m_f.ch = c; m_f.word = m_shadow[c]; m_f.start = cyc + 1 + c*P;
          m_f.len = DW*DIV + 2; m_f.nbits = DW;
          exp_q.push_back(m_f);
        end
        if (m_fresh != {NCH{1'b1}}) exp_under_q.push_back(cyc);
        exp_load_q.push_back(cyc);
`ifdef SPI_DAC_LDAC_EN
        exp_ldac_q.push_back(cyc + 1 + NCH*P);
`endif
        m_fresh = '0;
        m_busy_end = cyc + F;
        m_load_pend = 0;
      end
      if (s_axis_valid && int'(s_axis_chan) < NCH) begin
        m_shadow[s_axis_chan] = s_axis_data;
        m_fresh[s_axis_chan] = 1'b1;
      end
      if (en && m_cnt == MPS-1) begin
        if (cyc < m_busy_end) exp_over_q.push_back(cyc + 1);
        else m_load_pend = 1;
        m_cnt = 0;
      end else begin
        m_cnt = en ? m_cnt + 1 : 0;
      end
    end
    cyc++;
  end

  // pin monitor: decodes frames as the DAC would (bits taken on SCLK rise)
  int mon_multi_cs = 0, mon_idle_err = 0, mon_ldac_err = 0, mon_busy_err = 0;
  bit in_frame = 0;
  logic prev_sclk = 1'b1;
  int ldac_run = 0, busy_run = 0, nlow, idx;
  frame_t cur;

  always @(negedge mclk) begin
    if (!rst_n) begin
      in_frame = 0; prev_sclk = 1'b1; ldac_run = 0; busy_run = 0;
    end else begin
      nlow = 0; idx = 0;
      for (int i = 0; i < NCH; i++) if (cs_n[i] !== 1'b1) begin nlow++; idx = i; end
      if (nlow > 1) mon_multi_cs++;
      if (nlow == 0 && (sclk !== 1'b1 || mosi !== 1'b0)) mon_idle_err++;
      if (nlow == 1) begin
        if (in_frame && idx != cur.ch) begin obs_q.push_back(cur); in_frame = 0; end
        if (!in_frame) begin
          in_frame = 1; cur.ch = idx; cur.word = '0; cur.start = cyc; cur.len = 0; cur.nbits = 0;
        end
        cur.len++;
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
          cur.word = {cur.word[DW-2:0], mosi};
          cur.nbits++;
        end
      end else if (in_frame) begin
        obs_q.push_back(cur);
        in_frame = 0;
      end
      prev_sclk = sclk;
      if (underrun === 1'b1) obs_under_q.push_back(cyc);
      if (overrun === 1'b1) obs_over_q.push_back(cyc);
      if (busy === 1'b1) begin
        if (busy_run == 0) obs_load_q.push_back(cyc);
        busy_run++;
      end else begin
        if (busy_run != 0 && busy_run != F) mon_busy_err++;
        busy_run = 0;
      end
`ifdef SPI_DAC_LDAC_EN
      if (ldac_n === 1'b0) begin
        if (ldac_run == 0) obs_ldac_q.push_back(cyc);
        ldac_run++;
      end else begin
        if (ldac_run != 0 && ldac_run != LDC) mon_ldac_err++;
        ldac_run = 0;
      end
`else
      if (ldac_n !== 1'b0) mon_ldac_err++;
`endif
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(posedge mclk); #1; end
  endtask

  task automatic send(input int ch, input logic [DW-1:0] d);
    s_axis_valid = 1'b1; s_axis_chan = CHW'(ch); s_axis_data = d;
    step(1);
    s_axis_valid = 1'b0;
  endtask

  task automatic one_tick();
    en = 1'b1; step(MPS); en = 1'b0; step(F + 10);
  endtask

  task automatic flush();
    exp_q.delete(); obs_q.delete(); exp_under_q.delete(); obs_under_q.delete();
    exp_over_q.delete(); obs_over_q.delete(); exp_load_q.delete(); obs_load_q.delete();
    exp_ldac_q.delete(); obs_ldac_q.delete();
    mon_multi_cs = 0; mon_idle_err = 0; mon_ldac_err = 0; mon_busy_err = 0;
  endtask

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return 0;
    return 1;
  endfunction

  // scoreboard: drains model and monitor queues for one scenario
  task automatic check_scoreboard(input string name);
    int n;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s frame_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].ch != exp_q[i].ch || obs_q[i].word !== exp_q[i].word || obs_q[i].start != exp_q[i].start ||
          obs_q[i].len != exp_q[i].len || obs_q[i].nbits != exp_q[i].nbits) begin
        errors++;
        $display("FAIL %s frame%0d got ch=%0d word=%h start=%0d len=%0d bits=%0d exp ch=%0d word=%h start=%0d len=%0d bits=%0d",
                 name, i, obs_q[i].ch, obs_q[i].word, obs_q[i].start, obs_q[i].len, obs_q[i].nbits,
                 exp_q[i].ch, exp_q[i].word, exp_q[i].start, exp_q[i].len, exp_q[i].nbits);
      end
    end
    checks++;
    if (!q_eq(obs_under_q, exp_under_q)) begin
      errors++; $display("FAIL %s underrun_cycles got=%p exp=%p", name, obs_under_q, exp_under_q);
    end
    checks++;
    if (!q_eq(obs_over_q, exp_over_q)) begin
      errors++; $display("FAIL %s overrun_cycles got=%p exp=%p", name, obs_over_q, exp_over_q);
    end
    checks++;
    if (!q_eq(obs_load_q, exp_load_q)) begin
      errors++; $display("FAIL %s busy_start_cycles got=%p exp=%p", name, obs_load_q, exp_load_q);
    end
    checks++;
    if (!q_eq(obs_ldac_q, exp_ldac_q)) begin
      errors++; $display("FAIL %s ldac_start_cycles got=%p exp=%p", name, obs_ldac_q, exp_ldac_q);
    end
    checks++;
    if (mon_multi_cs != 0 || mon_idle_err != 0 || mon_ldac_err != 0 || mon_busy_err != 0) begin
      errors++;
      $display("FAIL %s pin_rules got multi_cs=%0d idle=%0d ldac=%0d busy_len=%0d exp all 0",
               name, mon_multi_cs, mon_idle_err, mon_ldac_err, mon_busy_err);
    end
    flush();
  endtask

  logic [DW-1:0] last_ch1;

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    checks++;
    if (cs_n !== {NCH{1'b1}} || sclk !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_pins got cs_n=%b sclk=%b mosi=%b busy=%b exp cs_n=111 sclk=1 mosi=0 busy=0", cs_n, sclk, mosi, busy);
    end
    checks++;
    if (underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags got underrun=%b overrun=%b exp 0 0", underrun, overrun);
    end
    checks++;
    if (ldac_n !== LDAC_IDLE) begin
      errors++; $display("FAIL reset_ldac got=%b exp=%b", ldac_n, LDAC_IDLE);
    end
    checks++;
    if (s_axis_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b exp=0", s_axis_ready);
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (s_axis_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got=%b exp=1", s_axis_ready);
    end
    flush();
  endtask

  task automatic test_single_frame();
    last_ch1 = DW'($urandom_range(0, 65535));
    send(0, 16'hA5C3);
    send(1, last_ch1);
    send(2, DW'($urandom_range(0, 65535)));
    send(3, DW'($urandom_range(0, 65535)));
    one_tick();
    checks++;
    if (obs_q.size() != NCH || obs_q[0].word !== 16'hA5C3 || obs_q[0].len != DW*DIV + 2) begin
      errors++; $display("FAIL single_frame_ch0 got frames=%0d word=%h len=%0d exp frames=%0d word=a5c3 len=%0d",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0].word : 16'h0, (obs_q.size() > 0) ? obs_q[0].len : 0, NCH, DW*DIV + 2);
    end
    check_scoreboard("single_frame");
  endtask

  task automatic test_underrun();
    send(0, DW'($urandom_range(0, 65535)));
    one_tick();
    checks++;
    if (obs_under_q.size() != 1 || obs_q.size() < 2 || obs_q[1].word !== last_ch1) begin
      errors++; $display("FAIL underrun_retransmit got pulses=%0d ch1=%h exp pulses=1 ch1=%h",
                         obs_under_q.size(), (obs_q.size() > 1) ? obs_q[1].word : 16'h0, last_ch1);
    end
    check_scoreboard("underrun");
  endtask

  task automatic test_load_collision();
    send(0, 16'h0001);
    send(1, DW'($urandom_range(0, 65535)));
    send(2, DW'($urandom_range(0, 65535)));
    en = 1'b1;
    step(MPS);
    en = 1'b0;
    send(0, 16'h0F0F);
    step(F + 10);
    send(1, DW'($urandom_range(0, 65535)));
    send(2, DW'($urandom_range(0, 65535)));
    one_tick();
    checks++;
    if (obs_q.size() != 2*NCH || obs_q[0].word !== 16'h0001 || obs_q[NCH].word !== 16'h0F0F) begin
      errors++; $display("FAIL load_collision got frames=%0d first=%h second=%h exp frames=%0d first=0001 second=0f0f",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0].word : 16'h0,
                         (obs_q.size() > NCH) ? obs_q[NCH].word : 16'h0, 2*NCH);
    end
    checks++;
    if (obs_under_q.size() != 0) begin
      errors++; $display("FAIL load_collision_underrun got=%0d pulses exp=0", obs_under_q.size());
    end
    check_scoreboard("load_collision");
  endtask

  task automatic test_overrun();
    for (int c = 0; c < NCH; c++) send(c, DW'($urandom_range(0, 65535)));
    en = 1'b1;
    for (int i = 0; i < 4*MPS; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        s_axis_valid = 1'b1;
        s_axis_chan = CHW'($urandom_range(0, 3));
        s_axis_data = DW'($urandom_range(0, 65535));
      end else begin
        s_axis_valid = 1'b0;
      end
      step(1);
    end
    s_axis_valid = 1'b0;
    en = 1'b0;
    step(F + 10);
    checks++;
    if (obs_over_q.size() != 2 || obs_q.size() != 2*NCH) begin
      errors++; $display("FAIL overrun_count got overruns=%0d frames=%0d exp overruns=2 frames=%0d",
                         obs_over_q.size(), obs_q.size(), 2*NCH);
    end
    check_scoreboard("overrun");
  endtask

  task automatic test_reset_mid_frame();
    for (int c = 0; c < NCH; c++) send(c, DW'($urandom_range(1, 65535)));
    en = 1'b1;
    step(MPS);
    en = 1'b0;
    step(20);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== {NCH{1'b1}} || sclk !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_frame got cs_n=%b sclk=%b mosi=%b busy=%b exp cs_n=111 sclk=1 mosi=0 busy=0", cs_n, sclk, mosi, busy);
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    flush();
    send(0, DW'($urandom_range(0, 65535)));
    one_tick();
    checks++;
    if (obs_q.size() != NCH || obs_q[1].word !== '0 || obs_q[2].word !== '0 || obs_under_q.size() != 1) begin
      errors++; $display("FAIL post_reset_shadows got frames=%0d ch1=%h ch2=%h underruns=%0d exp frames=%0d ch1=0000 ch2=0000 underruns=1",
                         obs_q.size(), (obs_q.size() > 1) ? obs_q[1].word : 16'hffff,
                         (obs_q.size() > 2) ? obs_q[2].word : 16'hffff, obs_under_q.size(), NCH);
    end
    check_scoreboard("reset_mid_frame");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_load_collision();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
